vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, column/line counters and registered sync/blank outputs.
// Define VGA_FRAME_COUNT_EN to keep the frame_count register; otherwise frame_count is tied to 0.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_VIS_START = 144,
    parameter int unsigned H_VIS_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_VIS_START = 35,
    parameter int unsigned V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick,
    output logic [7:0] frame_count
);
    localparam logic [3:0] DivLast   = 4'(CLK_DIV - 1);
    localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
    localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
    localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
    localparam logic [9:0] HVisStart = 10'(H_VIS_START);
    localparam logic [9:0] HVisEnd   = 10'(H_VIS_END);
    localparam logic [9:0] VVisStart = 10'(V_VIS_START);
    localparam logic [9:0] VVisEnd   = 10'(V_VIS_END);

    logic [3:0] div_q, div_d;
    logic       pix_q, pix_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       bright_q, bright_d;
    logic       tick_q, tick_d;
    logic       line_end;

    // Sync/blank are decoded from the next counter values so they land with the counters.
    always_comb begin
        div_d    = (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
        pix_d    = (div_d == DivLast);
        line_end = pix_q && (h_q == HLast);
        h_d      = h_q;
        v_d      = v_q;
        if (pix_q) begin
            h_d = line_end ? 10'd0 : h_q + 10'd1;
        end
        if (line_end) begin
            v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
        end
        hsync_d  = (h_d >= HSyncEnd);
        vsync_d  = (v_d >= VSyncEnd);
        bright_d = (h_d >= HVisStart) && (h_d < HVisEnd) &&
                   (v_d >= VVisStart) && (v_d < VVisEnd);
        tick_d   = line_end && (v_d == VVisEnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= 4'd0;
            pix_q    <= 1'b0;
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_q    <= pix_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
            tick_q   <= tick_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= 8'd0;
        end else if (tick_d) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 8'd0;
`endif

    assign pix_en     = pix_q;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign bright     = bright_q;
    assign frame_tick = tick_q;
endmodule
